// File: rtl/regfile_multiport.sv
// Multi-port register file with two write ports, NRD combinational read ports,
// optional write-to-read bypass and a self-clearing sweep after reset.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   we0/wa0/wd0    write port 0 (enable / address / data)
//   we1/wa1/wd1    write port 1; wins over port 0 on an address collision
//   ra             packed read addresses, port k at [k*AW +: AW]
//   rd             packed read data, port k at [k*XLEN +: XLEN] (combinational)
//   busy           high while the clear sweep is pending or running (combinational)
module regfile_multiport #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic                busy
);

  localparam logic [AW-1:0] LASTIDX = AW'(NREG - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state, stateNext;
  logic [AW-1:0]   cnt, cntNext;
  logic            clrWe;
  logic            wrEn0, wrEn1;
  logic [XLEN-1:0] regs [NREG];

  // Next-state and write-enable decode
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    clrWe     = 1'b0;
    if (!rst) begin
      stateNext = CLEAR;
      cntNext   = '0;
    end else if (state == CLEAR) begin
      clrWe   = 1'b1;
      cntNext = cnt + AW'(1);
      if (cnt == LASTIDX) stateNext = RUN;
    end
  end

  // Address 0 is hardwired to zero, so writes to it are dropped here
  assign wrEn0 = rst && (state == RUN) && we0 && (wa0 != '0);
  assign wrEn1 = rst && (state == RUN) && we1 && (wa1 != '0);

  // State, sweep counter and storage; port 1 assigned last so it wins collisions
  always_ff @(posedge clk) begin
    state <= stateNext;
    cnt   <= cntNext;
    if (clrWe) regs[cnt] <= '0;
    if (wrEn0) regs[wa0] <= wd0;
    if (wrEn1) regs[wa1] <= wd1;
  end

  assign busy = (state == CLEAR);

  // Read ports: optional same-cycle forwarding, forced to zero outside RUN
  always_comb begin
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
    addr = '0;
    val  = '0;
    rd   = '0;
    for (int k = 0; k < NRD; k++) begin
      addr = ra[k*AW +: AW];
      val  = regs[addr];
      if (BYPASS != 0) begin
        if (wrEn1 && (wa1 == addr))      val = wd1;
        else if (wrEn0 && (wa0 == addr)) val = wd0;
      end
      if (!rst || (state != RUN) || (addr == '0)) val = '0;
      rd[k*XLEN +: XLEN] = val;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: default-size instances with and without bypass share one
// stimulus stream; a small 4-read-port, 16-bit, 8-entry instance runs alongside.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rdA, rdB;
  logic        busyA, busyB;

  logic        weS0, weS1;
  logic [2:0]  waS0, waS1;
  logic [15:0] wdS0, wdS1;
  logic [11:0] raS;
  logic [63:0] rdS;
  logic        busyS;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dutA (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rd(rdA), .busy(busyA));

  regfile_multiport #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dutB (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rd(rdB), .busy(busyB));

  regfile_multiport #(.XLEN(16), .NREG(8), .NRD(4), .BYPASS(1)) dutS (
    .clk(clk), .rst(rst), .we0(weS0), .wa0(waS0), .wd0(wdS0),
    .we1(weS1), .wa1(waS1), .wd1(wdS1), .ra(raS), .rd(rdS), .busy(busyS));

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges taken with busy high, checking reads stay zero meanwhile
  task automatic sweepCount(output int nA, output int nB, output int nS, output bit rdBad);
    nA = 0; nB = 0; nS = 0; rdBad = 1'b0;
    ra  = {5'd9, 5'd3};
    raS = {3'd7, 3'd5, 3'd2, 3'd1};
    for (int e = 0; e < 200 && (busyA || busyB || busyS); e++) begin
      #1;
      if (rdA !== '0 || rdB !== '0 || rdS !== '0) rdBad = 1'b1;
      if (busyA) nA++;
      if (busyB) nB++;
      if (busyS) nS++;
      tick();
    end
  endtask

  initial begin
    int  nA, nB, nS;
    bit  rdBad;

    rst = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra  = {5'd4, 5'd2};
    weS0 = 1'b0; waS0 = '0; wdS0 = '0;
    weS1 = 1'b0; waS1 = '0; wdS1 = '0;
    raS = '0;

    // Hold reset for three edges
    repeat (3) tick();
    #1;
    checkVal("reset_busyA", 64'(busyA), 64'd1);
    checkVal("reset_rdA", rdA, 64'd0);
    checkVal("reset_rdB", rdB, 64'd0);

    rst = 1'b1;
    sweepCount(nA, nB, nS, rdBad);
    checkVal("sweep1_edgesA", 64'(nA), 64'd32);
    checkVal("sweep1_edgesB", 64'(nB), 64'd32);
    checkVal("sweep1_edgesS", 64'(nS), 64'd8);
    checkVal("sweep1_rd_zero", 64'(rdBad), 64'd0);
    checkVal("run_busyA", 64'(busyA), 64'd0);

    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      #1;
      checkVal($sformatf("clear1_A%0d", a), rdA, 64'd0);
    end
    checkVal("clear1_B", rdB, 64'd0);

    // Same-cycle write/read of addr 5
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra = {5'd0, 5'd5};
    #2;
    checkVal("byp_wr5_A", rdA[31:0], 64'hDEADBEEF);
    checkVal("nobyp_wr5_B", rdB[31:0], 64'h0);
    tick();
    we0 = 1'b0;
    #2;
    checkVal("after_wr5_A", rdA[31:0], 64'hDEADBEEF);
    checkVal("after_wr5_B", rdB[31:0], 64'hDEADBEEF);

    // Both ports write addr 7; port 1 wins
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra = {5'd7, 5'd7};
    #2;
    checkVal("collide_byp_A", rdA, {32'h22, 32'h22});
    checkVal("collide_nobyp_B", rdB, 64'h0);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #2;
    checkVal("collide_store_A", rdA, {32'h22, 32'h22});
    checkVal("collide_store_B", rdB, {32'h22, 32'h22});

    // Port 0 bypass still works when port 1 writes elsewhere
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0909;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h0000_1212; ra = {5'd12, 5'd9};
    #2;
    checkVal("dual_byp_A", rdA, {32'h1212, 32'h0909});
    tick();
    we0 = 1'b0; we1 = 1'b0;

    // Write to addr 0 is dropped
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
    #2;
    checkVal("zero_same_A", rdA, 64'h0);
    checkVal("zero_same_B", rdB, 64'h0);
    tick();
    we0 = 1'b0;
    #2;
    checkVal("zero_next_A", rdA, 64'h0);
    checkVal("zero_next_B", rdB, 64'h0);

    // Small instance: four ports reading 1,1,3,0
    weS0 = 1'b1; waS0 = 3'd1; wdS0 = 16'hA5A5;
    weS1 = 1'b1; waS1 = 3'd3; wdS1 = 16'h5A5A;
    tick();
    weS0 = 1'b0; weS1 = 1'b0;
    raS = {3'd0, 3'd3, 3'd1, 3'd1};
    #2;
    checkVal("small_p0", 64'(rdS[15:0]), 64'hA5A5);
    checkVal("small_p1", 64'(rdS[31:16]), 64'hA5A5);
    checkVal("small_p2", 64'(rdS[47:32]), 64'h5A5A);
    checkVal("small_p3", 64'(rdS[63:48]), 64'h0000);

    // Fill regs 1..31 with distinct values
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'hC000_0000 | 32'(i);
      tick();
    end
    we0 = 1'b0;
    ra = {5'd31, 5'd10};
    #2;
    checkVal("fill_A", rdA, {32'hC000_001F, 32'hC000_000A});
    checkVal("fill_B", rdB, {32'hC000_001F, 32'hC000_000A});

    // Second reset, interrupted at cnt=10 by a one-edge reset pulse
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    #1;
    checkVal("midsweep_busyA", 64'(busyA), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sweepCount(nA, nB, nS, rdBad);
    checkVal("sweep2_edgesA", 64'(nA), 64'd32);
    checkVal("sweep2_edgesB", 64'(nB), 64'd32);
    checkVal("sweep2_edgesS", 64'(nS), 64'd8);
    checkVal("sweep2_rd_zero", 64'(rdBad), 64'd0);

    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      #1;
      checkVal($sformatf("clear2_A%0d", a), rdA, 64'd0);
      checkVal($sformatf("clear2_B%0d", a), rdB, 64'd0);
    end
    raS = {3'd0, 3'd3, 3'd1, 3'd1};
    #1;
    checkVal("clear2_S", rdS, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter XLEN, default 32: register width in bits.
REQ-002 Parameter NREG, default 32: register count; power of two, 2..64; AW = log2(NREG).
REQ-003 Parameter NRD, default 2: number of read ports, 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 we0  in  1  write enable, port 0.
REQ-008 wa0  in  AW  write address, port 0.
REQ-009 wd0  in  XLEN  write data, port 0.
REQ-010 we1, wa1, wd1  in  1/AW/XLEN  write port 1, same meaning as port 0.
REQ-011 ra  in  NRD*AW  packed read addresses; port k at bits [k*AW +: AW].
REQ-012 rd  out  NRD*XLEN  packed read data; port k at bits [k*XLEN +: XLEN].
REQ-013 busy  out  1  high while the clear sweep is pending or running.

Function
REQ-014 Control FSM SHALL have two states: CLEAR and RUN, plus an AW-bit sweep counter cnt.
REQ-015 At any edge with rst=0: state<=CLEAR, cnt<=0, no register written.
REQ-016 In CLEAR with rst=1: each edge writes 0 to reg[cnt] and increments cnt; the edge with cnt=NREG-1 also sets state<=RUN.
REQ-017 The sweep SHALL take exactly NREG edges after rst rises; the first RUN cycle follows the NREG-th edge.
REQ-018 busy SHALL be 1 in CLEAR, otherwise 0; it is combinational from state.
REQ-019 In CLEAR, and while rst=0, we0 and we1 SHALL be ignored and every rd port SHALL read 0.
REQ-020 In RUN, weN=1 with waN!=0 SHALL write wdN to reg[waN] at the edge.
REQ-021 Writes to address 0 SHALL be dropped; reg[0] reads 0 at all times.
REQ-022 If both ports write the same non-zero address in one cycle, port 1's data SHALL be stored.
REQ-023 Reads SHALL be combinational, zero latency: rd[k] = reg[ra[k]].
REQ-024 With BYPASS=1 in RUN: if ra[k]!=0 matches an enabled write address in the same cycle, rd[k] SHALL return that write's data. Port 1 takes priority over port 0.
REQ-025 With BYPASS=0, rd[k] SHALL return the pre-edge contents; new data is visible the cycle after the write.
REQ-026 All read ports SHALL be independent; any number may address the same register.
REQ-027 rst falling mid-sweep or in RUN SHALL restart the sweep from cnt=0 on the next edge.

Reset
REQ-028 Reset SHALL be sampled only at clk rising edges; there SHALL be no asynchronous path to state.
REQ-029 After rst rises and NREG edges complete, every register SHALL hold 0, busy=0 and all rd=0.
REQ-030 No initial blocks SHALL be relied on for correct function; contents before the first sweep are undefined.

Verification
REQ-031 Hold rst=0 for 3 edges, then release; count edges with busy=1 -> exactly 32 (default); all rd=0 throughout; rd=0 for every address afterward.
REQ-032 RUN: we0=1, wa0=5, wd0=0xDEADBEEF; ra port0=5 in the same cycle -> rd0=0xDEADBEEF (BYPASS=1); with BYPASS=0 -> old value, then 0xDEADBEEF the next cycle.
REQ-033 Both ports write addr 7 (wd0=0x11, wd1=0x22) -> stored and bypassed value 0x22.
REQ-034 we0=1, wa0=0, wd0=0xFFFFFFFF -> rd for addr 0 stays 0 in the same and following cycles.
REQ-035 Write regs 1..31 with distinct values; assert rst=0 for 1 edge mid-sweep of a second reset (at cnt=10) -> sweep restarts; busy high for 32 more edges after release; all regs 0.
REQ-036 NRD=4, XLEN=16, NREG=8: four ports read addrs 1,1,3,0 after writes 1=0xA5A5, 3=0x5A5A -> 0xA5A5, 0xA5A5, 0x5A5A, 0x0000.
